// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift_engine datapath:
//   - operation codes presented on the 3-bit op input
//   - IDLE/RUN state encoding of the sequencing FSM
//   - helper that classifies an op code as a shifting operation
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam logic [2:0] OP_LOAD = 3'd0;  // parallel load
  localparam logic [2:0] OP_SHL  = 3'd1;  // logical left, SL fill
  localparam logic [2:0] OP_SHR  = 3'd2;  // logical right, SR fill
  localparam logic [2:0] OP_SAR  = 3'd3;  // arithmetic right, sign fill
  localparam logic [2:0] OP_ROL  = 3'd4;  // rotate left
  localparam logic [2:0] OP_ROR  = 3'd5;  // rotate right
  // 3'd6 and 3'd7 are reserved and behave as a no-op with done

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational single-step shifter: moves q by s positions according to op.
// Fill bits entering on a multi-position step are replicated s times.
// Ports:
//   q      in  WIDTH  current register contents
//   op     in  3      operation (shift_pkg op codes); non-shift ops pass q
//   s      in  SW     positions to move this step (1..STEP; 0 passes q)
//   SR     in  1      fill bit entering at the MSB on logical right shifts
//   SL     in  1      fill bit entering at the LSB on logical left shifts
//   q_next out WIDTH  shifted value
// -----------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = 6
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic [SW-1:0]    s,
  input  logic             SR,
  input  logic             SL,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] fill_lo;  // low s bits set
  logic [WIDTH-1:0] fill_hi;  // high s bits set
  int unsigned      sh;

  always_comb begin
    sh      = 32'(s);
    ones    = '1;
    fill_lo = ~(ones << sh);
    fill_hi = ~(ones >> sh);
    q_next  = q;
    case (op)
      OP_SHL:  q_next = (q << sh) | (SL ? fill_lo : '0);
      OP_SHR:  q_next = (q >> sh) | (SR ? fill_hi : '0);
      OP_SAR:  q_next = $unsigned($signed(q) >>> sh);
      // A shift by WIDTH yields zero, so s == WIDTH rotates back to q.
      OP_ROL:  q_next = (q << sh) | (q >> (32'(WIDTH) - sh));
      OP_ROR:  q_next = (q >> sh) | (q << (32'(WIDTH) - sh));
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_engine.sv
// -----------------------------------------------------------------------------
// shift_engine
// Multi-cycle shift/rotate engine. A request is accepted in IDLE; shift ops with
// a non-zero amount run in RUN, moving up to STEP positions per clock until the
// remaining count reaches zero, then pulse done for one cycle.
//
// Handshake: start is sampled only while busy=0 (IDLE). op, amt and pdata are
// captured on the accepting edge; later changes are ignored. done is a
// one-cycle pulse in the cycle after the final edge, during which the engine is
// IDLE again and a new start is accepted (zero bubble). A start while busy=1 is
// dropped, not queued.
//
// Ports:
//   clk        in  1      rising-edge clock
//   clear      in  1      asynchronous active-high reset (aborts any operation)
//   start      in  1      request
//   op         in  3      operation
//   amt        in  AW     shift count 0..WIDTH-1
//   pdata      in  WIDTH  parallel load data
//   SR, SL     in  1      fill bits, sampled live each shift cycle
//   q          out WIDTH  register contents
//   busy       out 1      high while RUN
//   done       out 1      completion pulse
//   dbg_state  out state  FSM state for observation
// -----------------------------------------------------------------------------
module shift_engine
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] pdata,
  input  logic             SR,
  input  logic             SL,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  // One extra bit so that STEP == WIDTH is representable.
  localparam int           SW     = AW + 1;
  localparam logic [SW-1:0] STEP_C = SW'(STEP);

  state_t           state_q, state_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SW-1:0]    rem_ext;
  logic [SW-1:0]    s;
  logic [WIDTH-1:0] step_q;

  // Positions moved this cycle: min(STEP, rem).
  always_comb begin
    rem_ext = {1'b0, rem_q};
    s       = (rem_ext < STEP_C) ? rem_ext : STEP_C;
  end

  shift_step #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_step (
    .q      (q_q),
    .op     (op_q),
    .s      (s),
    .SR     (SR),
    .SL     (SL),
    .q_next (step_q)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_LOAD) begin
            q_d    = pdata;
            done_d = 1'b1;
          end else if (is_shift_op(op) && (amt != '0)) begin
            op_d    = op;
            rem_d   = amt;
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end else begin
            // Zero amount or reserved op: complete immediately, q untouched.
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        q_d   = step_q;
        // s <= rem by construction, so this never wraps.
        rem_d = AW'(rem_ext - s);
        if (rem_ext == s) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= OP_LOAD;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q         = q_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_shift_engine
// Directed bench for shift_engine with two instances: STEP=1 (u_s1) and
// STEP=4 (u_s4), both WIDTH=32. Inputs are driven 1 time unit after the rising
// edge; outputs are observed at that same point.
// -----------------------------------------------------------------------------
module tb_shift_engine;
  import shift_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        clear = 1'b1;
  always #5 clk = ~clk;

  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [2:0]  op     = 3'd0;
  logic [4:0]  amt    = 5'd0;
  logic [31:0] pdata  = 32'd0;
  logic        sr     = 1'b0;
  logic        sl     = 1'b0;

  logic [31:0] q1, q4;
  logic        busy1, busy4, done1, done4;
  state_t      st1, st4;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  shift_engine #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .clear(clear), .start(start1), .op(op), .amt(amt),
    .pdata(pdata), .SR(sr), .SL(sl), .q(q1), .busy(busy1), .done(done1),
    .dbg_state(st1)
  );

  shift_engine #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .clear(clear), .start(start4), .op(op), .amt(amt),
    .pdata(pdata), .SR(sr), .SL(sl), .q(q4), .busy(busy4), .done(done4),
    .dbg_state(st4)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] q_of(input int which);
    return (which == 4) ? q4 : q1;
  endfunction
  function automatic logic done_of(input int which);
    return (which == 4) ? done4 : done1;
  endfunction
  function automatic logic busy_of(input int which);
    return (which == 4) ? busy4 : busy1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents one request for one edge; the engine accepts it on that edge.
  task automatic issue(input int which, input logic [2:0] o, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] expect_q);
    op    = o;
    amt   = a;
    pdata = d;
    if (which == 4) start4 = 1'b1;
    else            start1 = 1'b1;
    exp_q.push_back(expect_q);
    tick();
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Counts edges after acceptance until done, bounded; checks latency,
  // busy duration, final q and optionally that done drops after one cycle.
  task automatic wait_done(input int which, input string tag, input int exp_j,
                           input int exp_busy, input bit check_drop);
    int j  = 0;
    int bc = 0;
    logic [31:0] e;
    while (!done_of(which) && j < 64) begin
      if (busy_of(which)) bc++;
      tick();
      j++;
    end
    e = exp_q.pop_front();
    check({tag, " latency"},     32'(j),  32'(exp_j));
    check({tag, " busy cycles"}, 32'(bc), 32'(exp_busy));
    check({tag, " busy at done"}, {31'b0, busy_of(which)}, 32'd0);
    check({tag, " q"},           q_of(which), e);
    if (check_drop) begin
      tick();
      check({tag, " done width"}, {31'b0, done_of(which)}, 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int done_seen;

    // Reset state
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset q1",    q1, 32'h0);
    check("reset q4",    q4, 32'h0);
    check("reset busy1", {31'b0, busy1}, 32'd0);
    check("reset done1", {31'b0, done1}, 32'd0);
    check("reset busy4", {31'b0, busy4}, 32'd0);
    clear = 1'b0;
    tick();

    // STEP=1: LOAD, SAR 4, reload, ROL 1
    issue(1, OP_LOAD, 5'd0, 32'h8000_0001, 32'h8000_0001);
    wait_done(1, "load 80000001", 0, 0, 1'b1);
    issue(1, OP_SAR, 5'd4, 32'h0, 32'hF800_0000);
    check("sar busy after accept", {31'b0, busy1}, 32'd1);
    check("sar state after accept", 32'(st1), 32'(ST_RUN));
    wait_done(1, "sar 4", 4, 4, 1'b1);
    issue(1, OP_LOAD, 5'd0, 32'h8000_0001, 32'h8000_0001);
    wait_done(1, "reload", 0, 0, 1'b1);
    issue(1, OP_ROL, 5'd1, 32'h0, 32'h0000_0003);
    wait_done(1, "rol 1", 1, 1, 1'b1);

    // STEP=4: SHR 10 with SR=0, then SR=1
    sr = 1'b0;
    issue(4, OP_LOAD, 5'd0, 32'hFFFF_0000, 32'hFFFF_0000);
    wait_done(4, "s4 load", 0, 0, 1'b1);
    issue(4, OP_SHR, 5'd10, 32'h0, 32'h003F_FFC0);
    tick();
    check("s4 shr first step", q4, 32'h0FFF_F000);
    wait_done(4, "s4 shr10 sr0", 2, 2, 1'b1);
    sr = 1'b1;
    issue(4, OP_LOAD, 5'd0, 32'hFFFF_0000, 32'hFFFF_0000);
    wait_done(4, "s4 reload", 0, 0, 1'b1);
    issue(4, OP_SHR, 5'd10, 32'h0, 32'hFFFF_FFC0);
    wait_done(4, "s4 shr10 sr1", 3, 3, 1'b1);
    sr = 1'b0;

    // STEP=1: start during RUN ignored, clear mid-RUN aborts
    sl = 1'b0;
    issue(1, OP_LOAD, 5'd0, 32'h0000_00FF, 32'h0000_00FF);
    wait_done(1, "load ff", 0, 0, 1'b1);
    op = OP_SHL; amt = 5'd8; start1 = 1'b1;
    tick();                    // accepted
    start1 = 1'b0;
    tick();                    // one shift done
    op = OP_LOAD; pdata = 32'hDEAD_BEEF; start1 = 1'b1;
    tick();                    // start while busy
    start1 = 1'b0;
    check("start while busy q", q1, 32'h0000_03FC);
    check("start while busy busy", {31'b0, busy1}, 32'd1);
    tick();
    check("shl third step", q1, 32'h0000_07F8);
    #1 clear = 1'b1;
    #1;
    check("clear q",     q1, 32'h0);
    check("clear busy",  {31'b0, busy1}, 32'd0);
    check("clear done",  {31'b0, done1}, 32'd0);
    check("clear state", 32'(st1), 32'(ST_IDLE));
    #1 clear = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done1) done_seen++;
    end
    check("no done after clear", 32'(done_seen), 32'd0);
    check("q stays 0 after clear", q1, 32'h0);
    issue(1, OP_LOAD, 5'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    wait_done(1, "load after clear", 0, 0, 1'b1);

    // amt=0, reserved op, back-to-back accept in the done cycle
    issue(1, OP_LOAD, 5'd0, 32'h1234_5678, 32'h1234_5678);
    wait_done(1, "load 12345678", 0, 0, 1'b1);
    issue(1, OP_SHL, 5'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    wait_done(1, "shl amt0", 0, 0, 1'b1);
    issue(1, 3'd6, 5'd5, 32'hFFFF_FFFF, 32'h1234_5678);
    wait_done(1, "reserved op6", 0, 0, 1'b0);
    issue(1, OP_SHR, 5'd4, 32'h0, 32'h0123_4567);
    check("b2b accepted busy", {31'b0, busy1}, 32'd1);
    wait_done(1, "b2b shr4", 4, 4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
